qhv_collector: RTL and testbench
================================

// Module: qhv_collector
// PURPOSE
//  Downstream of the quantizer FSM. Captures quantized HV segments (one per cycle while mapping_hv_segment=1, slot = ctr).
//  Applies the pruning keep-mask and assembles full HVs in a 2-entry ping-pong buffer.
//  Presents each complete HV to the similarity/AM stage over a valid/ready handshake.
//  Drives busy back upstream so a new mapping is not started while both banks are occupied.
// PARAMETERS
//  SEG_W            64   bits per quantized segment
//  SEQ_CYCLE_COUNT  4    segments per HV (matches quantizer ctr range)
//  HV_W             SEG_W*SEQ_CYCLE_COUNT (localparam, not overridable)
//  IDX_W            $clog2(SEQ_CYCLE_COUNT) (localparam, min 1)
// PORTS
//  clk         in   1      clock
//  nrst        in   1      reset, asynchronous, active-low
//  en          in   1      global enable; 0 = ignore seg_valid/map_done, hold all state
//  seg_valid   in   1      segment strobe (quantizer mapping_hv_segment)
//  seg_idx     in   IDX_W  segment slot (quantizer ctr)
//  seg_data    in   SEG_W  quantized segment data
//  map_done    in   1      end-of-HV pulse (quantizer mapping_done)
//  prune_mask  in   HV_W   1 = keep dimension, 0 = pruned (forced 0)
//  hv_out      out  HV_W   assembled, masked HV from the read bank
//  hv_valid    out  1      hv_out holds a complete HV
//  hv_ready    in   1      consumer accepts hv_out
//  busy        out  1      both banks full; upstream must not assert start_mapping
//  err_seq     out  1      sticky protocol error; cleared only by reset
// BEHAVIOUR
//  Reset: banks 0, full[1:0]=0, wb=rb=0, exp_idx=0, rcvd=0, hv_valid=0, busy=0, err_seq=0, hv_out=0.
//  Write FSM states: W_IDLE (rcvd==0) and W_FILL (rcvd!=0).
//   - W_IDLE->W_FILL on the first accepted segment.
//   - W_FILL->W_IDLE on map_done (commit or discard).
//  Segment accept: en && seg_valid && !full[wb].
//   - bank[wb][seg_idx*SEG_W +: SEG_W] <= seg_data & prune_mask[same slice].
//   - rcvd[seg_idx] <= 1; exp_idx <= exp_idx+1 (wraps at SEQ_CYCLE_COUNT).
//   - seg_idx != exp_idx -> err_seq=1; write still performed.
//  Overflow: en && seg_valid && full[wb] -> segment dropped, err_seq=1.
//  map_done (en=1):
//   - rcvd all-ones -> full[wb]<=1, wb<=~wb, rcvd<=0, exp_idx<=0.
//   - otherwise -> discard: rcvd<=0, exp_idx<=0, err_seq=1, wb unchanged.
//   - seg_valid in the same cycle as map_done: illegal; segment dropped, err_seq=1.
//  Read side:
//   - hv_valid = full[rb]; hv_out = bank[rb] (registered storage, no comb path from inputs).
//   - Pop on hv_valid && hv_ready: full[rb]<=0, rb<=~rb.
//   - hv_ready is not gated by en.
//   - hv_out/hv_valid stable while hv_valid && !hv_ready.
//  Latency: map_done at edge t -> hv_valid=1 after edge t if no older HV is pending; otherwise strict FIFO order.
//  Simultaneous commit + pop: both take effect the same cycle; never loses or duplicates an HV.
//  busy = full[0] & full[1], registered, updated the same edge as full.
//  Mask is sampled per segment at write time; later mask changes do not alter stored HVs.
//  Reset mid-fill or mid-hold: everything returns to reset values; partial HV is lost.
// STRUCTURE
//  hdc_pkg: SEG_W, SEQ_CYCLE_COUNT defaults; typedef seg_idx_t; typedef enum wstate_t {W_IDLE, W_FILL}.
//  Sub-module qhv_bank (x2): HV_W register with slice write-enable and masking.
//  Top level holds the write FSM, wb/rb pointers, full flags and error logic.
// TESTING
//  1 Reset, then segs idx 0..3 = A,B,C,D, mask all-ones, map_done -> next cycle hv_valid=1, hv_out={D,C,B,A}.
//  2 Mask = alternating 0xAAAA.. -> hv_out = data & 0xAAAA..; mask change after commit leaves hv_out unchanged.
//  3 hv_ready=0, commit two HVs -> busy=1; third HV segs dropped, err_seq=1; pop -> busy=0, first HV out first.
//  4 Commit with hv_ready=1 held -> commit and pop in the same cycles; 8 back-to-back HVs, outputs in order, none lost.
//  5 Segment order 0,2,1,3 -> err_seq=1, HV still complete. Only 3 segs then map_done -> discard, hv_valid stays 0.
//  6 nrst low mid-fill after seg 1 -> all outputs 0; fresh full sequence afterwards gives a correct HV, err_seq=0.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared types and default sizes for the HDC quantized-HV datapath.
// Consumed by the collector and its bank storage.
package hdc_pkg;

    localparam int SEG_W_DEF           = 64;
    localparam int SEQ_CYCLE_COUNT_DEF = 4;

    // Slot index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(SEQ_CYCLE_COUNT_DEF);

    typedef logic [IDX_W_DEF-1:0] seg_idx_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wstate_t;

endpackage

// File: rtl/qhv_bank.sv
// One HV-wide storage bank: writes a single segment slot per cycle,
// applying the pruning mask slice at write time.
module qhv_bank
    import hdc_pkg::*;
#(
    parameter int  SEG_W           = SEG_W_DEF,
    parameter int  SEQ_CYCLE_COUNT = SEQ_CYCLE_COUNT_DEF,
    localparam int HV_W            = SEG_W * SEQ_CYCLE_COUNT,
    localparam int IDX_W           = idx_width(SEQ_CYCLE_COUNT)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [SEG_W-1:0] seg_data,
    input  logic [HV_W-1:0]  prune_mask,
    output logic [HV_W-1:0]  hv
);

    // NOTE: the bank is cleared by reset because hv_out must read zero out of reset;
    // a plain RAM without reset would leave X on the output until first fill.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hv <= '0;
        end else if (we) begin
            hv[idx*SEG_W +: SEG_W] <= seg_data & prune_mask[idx*SEG_W +: SEG_W];
        end
    end

endmodule

// File: rtl/qhv_collector.sv
// Collects quantized HV segments into a two-bank ping-pong buffer and
// hands complete, pruned HVs to the similarity stage over valid/ready.
module qhv_collector
    import hdc_pkg::*;
#(
    parameter int  SEG_W           = SEG_W_DEF,
    parameter int  SEQ_CYCLE_COUNT = SEQ_CYCLE_COUNT_DEF,
    localparam int HV_W            = SEG_W * SEQ_CYCLE_COUNT,
    localparam int IDX_W           = idx_width(SEQ_CYCLE_COUNT)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             seg_valid,
    input  logic [IDX_W-1:0] seg_idx,
    input  logic [SEG_W-1:0] seg_data,
    input  logic             map_done,
    input  logic [HV_W-1:0]  prune_mask,
    output logic [HV_W-1:0]  hv_out,
    output logic             hv_valid,
    input  logic             hv_ready,
    output logic             busy,
    output logic             err_seq
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_CYCLE_COUNT - 1);
    localparam logic [IDX_W:0]   SLOT_CNT  = (IDX_W + 1)'(SEQ_CYCLE_COUNT);

    wstate_t                    state, state_nxt;
    logic                       wb, wb_nxt;
    logic                       rb, rb_nxt;
    logic [1:0]                 full, full_nxt;
    logic [IDX_W-1:0]           exp_idx, exp_idx_nxt;
    logic [SEQ_CYCLE_COUNT-1:0] rcvd, rcvd_nxt;
    logic                       err_nxt;
    logic                       seg_we;
    logic                       idx_ok;
    logic                       pop;
    logic [HV_W-1:0]            bank_hv [2];

    assign idx_ok = ({1'b0, seg_idx} < SLOT_CNT);
    assign pop    = full[rb] & hv_ready;

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        wb_nxt      = wb;
        rb_nxt      = rb;
        full_nxt    = full;
        exp_idx_nxt = exp_idx;
        rcvd_nxt    = rcvd;
        err_nxt     = err_seq;
        seg_we      = 1'b0;

        // Pop is independent of en so the consumer can always drain.
        if (pop) begin
            full_nxt[rb] = 1'b0;
            rb_nxt       = ~rb;
        end

        if (en) begin
            if (seg_valid) begin
                if (map_done || full[wb] || !idx_ok) begin
                    err_nxt = 1'b1;
                end else begin
                    seg_we             = 1'b1;
                    rcvd_nxt[seg_idx]  = 1'b1;
                    exp_idx_nxt        = (exp_idx == LAST_IDX) ? '0 : exp_idx + IDX_W'(1);
                    state_nxt          = W_FILL;
                    if (seg_idx != exp_idx) begin
                        err_nxt = 1'b1;
                    end
                end
            end

            if (map_done) begin
                rcvd_nxt    = '0;
                exp_idx_nxt = '0;
                state_nxt   = W_IDLE;
                if (state == W_FILL && (&rcvd) && !full[wb]) begin
                    full_nxt[wb] = 1'b1;
                    wb_nxt       = ~wb;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= W_IDLE;
            wb      <= 1'b0;
            rb      <= 1'b0;
            full    <= '0;
            busy    <= 1'b0;
            exp_idx <= '0;
            rcvd    <= '0;
            err_seq <= 1'b0;
        end else begin
            state   <= state_nxt;
            wb      <= wb_nxt;
            rb      <= rb_nxt;
            full    <= full_nxt;
            busy    <= &full_nxt;
            exp_idx <= exp_idx_nxt;
            rcvd    <= rcvd_nxt;
            err_seq <= err_nxt;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        qhv_bank #(
            .SEG_W           (SEG_W),
            .SEQ_CYCLE_COUNT (SEQ_CYCLE_COUNT)
        ) u_bank (
            .clk        (clk),
            .nrst       (nrst),
            .we         (seg_we && (wb == 1'(b))),
            .idx        (seg_idx),
            .seg_data   (seg_data),
            .prune_mask (prune_mask),
            .hv         (bank_hv[b])
        );
    end

    assign hv_valid = full[rb];
    assign hv_out   = bank_hv[rb];

endmodule

// File: tb/tb_qhv_collector.sv
// Self-checking bench for qhv_collector: directed scenarios plus randomized
// streams checked against a queue-based FIFO model of complete HVs.
module tb_qhv_collector;

    localparam int SEG_W = 64;
    localparam int NSEG  = 4;
    localparam int HV_W  = SEG_W * NSEG;

    logic             clk;
    logic             nrst;
    logic             en;
    logic             seg_valid;
    logic [1:0]       seg_idx;
    logic [SEG_W-1:0] seg_data;
    logic             map_done;
    logic [HV_W-1:0]  prune_mask;
    logic [HV_W-1:0]  hv_out;
    logic             hv_valid;
    logic             hv_ready;
    logic             busy;
    logic             err_seq;

    int n_checks;
    int n_errors;

    qhv_collector #(.SEG_W(SEG_W), .SEQ_CYCLE_COUNT(NSEG)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .seg_valid  (seg_valid),
        .seg_idx    (seg_idx),
        .seg_data   (seg_data),
        .map_done   (map_done),
        .prune_mask (prune_mask),
        .hv_out     (hv_out),
        .hv_valid   (hv_valid),
        .hv_ready   (hv_ready),
        .busy       (busy),
        .err_seq    (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SEG_W-1:0] rand_seg();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [HV_W-1:0] rand_hv();
        logic [HV_W-1:0] v;
        for (int i = 0; i < NSEG; i++) v[i*SEG_W +: SEG_W] = rand_seg();
        return v;
    endfunction

    task automatic idle_inputs();
        seg_valid = 1'b0;
        seg_idx   = '0;
        seg_data  = '0;
        map_done  = 1'b0;
        hv_ready  = 1'b0;
        en        = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_seg(input int idx, input logic [SEG_W-1:0] d);
        seg_valid = 1'b1;
        seg_idx   = 2'(idx);
        seg_data  = d;
        tick(1);
        seg_valid = 1'b0;
    endtask

    task automatic drive_done();
        map_done = 1'b1;
        tick(1);
        map_done = 1'b0;
    endtask

    // Sends one HV in ascending slot order; returns the expected masked HV.
    task automatic send_hv(output logic [HV_W-1:0] expv);
        logic [SEG_W-1:0] d;
        for (int i = 0; i < NSEG; i++) begin
            d = rand_seg();
            expv[i*SEG_W +: SEG_W] = d & prune_mask[i*SEG_W +: SEG_W];
            drive_seg(i, d);
        end
        drive_done();
    endtask

    task automatic test_reset();
        idle_inputs();
        seg_valid  = 1'b1;
        seg_data   = rand_seg();
        map_done   = 1'b1;
        hv_ready   = 1'b1;
        prune_mask = '1;
        nrst       = 1'b0;
        tick(3);
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hv_valid: got %b want 0", hv_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (err_seq !== 1'b0) begin n_errors++; $display("FAIL reset_err_seq: got %b want 0", err_seq); end
        n_checks++; if (hv_out !== '0) begin n_errors++; $display("FAIL reset_hv_out: got %h want 0", hv_out); end
        idle_inputs();
        nrst = 1'b1;
        tick(2);
        n_checks++; if (hv_valid !== 1'b0 || err_seq !== 1'b0) begin n_errors++; $display("FAIL reset_release: got valid=%b err=%b want 0/0", hv_valid, err_seq); end
    endtask

    task automatic test_basic();
        logic [SEG_W-1:0] s [NSEG];
        apply_reset();
        prune_mask = '1;
        for (int i = 0; i < NSEG; i++) begin
            s[i] = rand_seg();
            drive_seg(i, s[i]);
        end
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid: got %b want 0", hv_valid); end
        drive_done();
        n_checks++; if (hv_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b want 1", hv_valid); end
        n_checks++; if (hv_out !== {s[3], s[2], s[1], s[0]}) begin n_errors++; $display("FAIL basic_hv_out: got %h want %h", hv_out, {s[3], s[2], s[1], s[0]}); end
        n_checks++; if (busy !== 1'b0 || err_seq !== 1'b0) begin n_errors++; $display("FAIL basic_flags: got busy=%b err=%b want 0/0", busy, err_seq); end
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL basic_pop: got %b want 0", hv_valid); end
    endtask

    task automatic test_mask();
        logic [HV_W-1:0] expv;
        apply_reset();
        prune_mask = {NSEG{64'hAAAA_AAAA_AAAA_AAAA}};
        send_hv(expv);
        n_checks++; if (hv_out !== expv) begin n_errors++; $display("FAIL mask_apply: got %h want %h", hv_out, expv); end
        n_checks++; if ((hv_out & ~prune_mask) !== '0) begin n_errors++; $display("FAIL mask_pruned_bits: got %h want 0", hv_out & ~prune_mask); end
        prune_mask = '0;
        tick(3);
        n_checks++; if (hv_out !== expv || hv_valid !== 1'b1) begin n_errors++; $display("FAIL mask_late_change: got %h want %h", hv_out, expv); end
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
    endtask

    task automatic test_busy_overflow();
        logic [HV_W-1:0] hv1, hv2, hv3;
        apply_reset();
        prune_mask = rand_hv();
        send_hv(hv1);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ovf_busy_one: got %b want 0", busy); end
        send_hv(hv2);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ovf_busy_two: got %b want 1", busy); end
        n_checks++; if (hv_out !== hv1) begin n_errors++; $display("FAIL ovf_hold_first: got %h want %h", hv_out, hv1); end
        n_checks++; if (err_seq !== 1'b0) begin n_errors++; $display("FAIL ovf_err_early: got %b want 0", err_seq); end
        send_hv(hv3);
        n_checks++; if (err_seq !== 1'b1) begin n_errors++; $display("FAIL ovf_err: got %b want 1", err_seq); end
        n_checks++; if (hv_out !== hv1 || busy !== 1'b1) begin n_errors++; $display("FAIL ovf_no_corrupt: got %h want %h", hv_out, hv1); end
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
        n_checks++; if (busy !== 1'b0 || hv_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_after_pop: got busy=%b valid=%b want 0/1", busy, hv_valid); end
        n_checks++; if (hv_out !== hv2) begin n_errors++; $display("FAIL ovf_second: got %h want %h", hv_out, hv2); end
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained: got %b want 0", hv_valid); end
    endtask

    // Stream of HVs against a FIFO model; random_ready exercises hold and commit+pop overlap.
    task automatic test_back_to_back(input bit random_ready, input int n_hv);
        logic [HV_W-1:0] q [$];
        logic [HV_W-1:0] cur;
        logic [SEG_W-1:0] d;
        int sent = 0;
        int got = 0;
        int seg_ptr = 0;
        apply_reset();
        prune_mask = rand_hv();
        for (int cyc = 0; cyc < n_hv * 14 + 40; cyc++) begin
            n_checks++; if (hv_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL b2b_valid cyc %0d: got %b want %b", cyc, hv_valid, q.size() != 0); end
            n_checks++; if (busy !== (q.size() == 2)) begin n_errors++; $display("FAIL b2b_busy cyc %0d: got %b want %b", cyc, busy, q.size() == 2); end
            if (q.size() != 0) begin
                n_checks++; if (hv_out !== q[0]) begin n_errors++; $display("FAIL b2b_data cyc %0d: got %h want %h", cyc, hv_out, q[0]); end
            end
            hv_ready  = (random_ready && sent < n_hv) ? 1'($urandom_range(0, 1)) : 1'b1;
            seg_valid = 1'b0;
            map_done  = 1'b0;
            if (sent < n_hv && (seg_ptr != 0 || q.size() < 2)) begin
                if (seg_ptr < NSEG) begin
                    d = rand_seg();
                    seg_valid = 1'b1;
                    seg_idx   = 2'(seg_ptr);
                    seg_data  = d;
                    cur[seg_ptr*SEG_W +: SEG_W] = d & prune_mask[seg_ptr*SEG_W +: SEG_W];
                    seg_ptr++;
                end else begin
                    map_done = 1'b1;
                    seg_ptr  = 0;
                    sent++;
                end
            end
            if (hv_valid && hv_ready && q.size() != 0) begin
                q.pop_front();
                got++;
            end
            if (map_done) q.push_back(cur);
            tick(1);
        end
        idle_inputs();
        n_checks++; if (got != n_hv) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", got, n_hv); end
        n_checks++; if (err_seq !== 1'b0) begin n_errors++; $display("FAIL b2b_err: got %b want 0", err_seq); end
    endtask

    task automatic test_seq_err();
        int ord [NSEG] = '{0, 2, 1, 3};
        logic [HV_W-1:0] expv;
        logic [HV_W-1:0] expv2;
        logic [SEG_W-1:0] d;
        apply_reset();
        prune_mask = '1;
        for (int i = 0; i < NSEG; i++) begin
            d = rand_seg();
            expv[ord[i]*SEG_W +: SEG_W] = d;
            drive_seg(ord[i], d);
        end
        n_checks++; if (err_seq !== 1'b1) begin n_errors++; $display("FAIL seq_err_flag: got %b want 1", err_seq); end
        drive_done();
        n_checks++; if (hv_valid !== 1'b1 || hv_out !== expv) begin n_errors++; $display("FAIL seq_err_hv: got %h want %h", hv_out, expv); end
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
        for (int i = 0; i < NSEG - 1; i++) drive_seg(i, rand_seg());
        drive_done();
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL seq_discard: got %b want 0", hv_valid); end
        tick(2);
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL seq_discard_hold: got %b want 0", hv_valid); end
        send_hv(expv2);
        n_checks++; if (hv_valid !== 1'b1 || hv_out !== expv2) begin n_errors++; $display("FAIL seq_recover: got %h want %h", hv_out, expv2); end
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
    endtask

    task automatic test_enable();
        logic [HV_W-1:0] expv;
        apply_reset();
        prune_mask = '1;
        en = 1'b0;
        send_hv(expv);
        tick(1);
        n_checks++; if (hv_valid !== 1'b0 || err_seq !== 1'b0) begin n_errors++; $display("FAIL en_ignore: got valid=%b err=%b want 0/0", hv_valid, err_seq); end
        en = 1'b1;
        send_hv(expv);
        n_checks++; if (hv_valid !== 1'b1 || hv_out !== expv) begin n_errors++; $display("FAIL en_commit: got %h want %h", hv_out, expv); end
        en = 1'b0;
        hv_ready = 1'b1;
        tick(1);
        hv_ready = 1'b0;
        en = 1'b1;
        n_checks++; if (hv_valid !== 1'b0) begin n_errors++; $display("FAIL en_pop_ungated: got %b want 0", hv_valid); end
    endtask

    task automatic test_reset_midfill();
        logic [HV_W-1:0] expv;
        apply_reset();
        prune_mask = '1;
        send_hv(expv);
        drive_done();
        drive_seg(0, rand_seg());
        drive_seg(1, rand_seg());
        n_checks++; if (hv_valid !== 1'b1 || err_seq !== 1'b1) begin n_errors++; $display("FAIL midfill_pre: got valid=%b err=%b want 1/1", hv_valid, err_seq); end
        #2 nrst = 1'b0;
        #1;
        n_checks++; if (hv_valid !== 1'b0 || busy !== 1'b0 || err_seq !== 1'b0 || hv_out !== '0) begin n_errors++; $display("FAIL midfill_async: got valid=%b busy=%b err=%b out=%h want all 0", hv_valid, busy, err_seq, hv_out); end
        @(posedge clk);
        #1 nrst = 1'b1;
        tick(1);
        send_hv(expv);
        n_checks++; if (hv_valid !== 1'b1 || hv_out !== expv) begin n_errors++; $display("FAIL midfill_fresh: got %h want %h", hv_out, expv); end
        n_checks++; if (err_seq !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL midfill_flags: got err=%b busy=%b want 0/0", err_seq, busy); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nrst = 1'b0;
        idle_inputs();
        prune_mask = '1;
        test_reset();
        test_basic();
        test_mask();
        test_busy_overflow();
        test_back_to_back(1'b0, 8);
        test_back_to_back(1'b1, 16);
        test_seq_err();
        test_enable();
        test_reset_midfill();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
